// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a standard or FWFT read port.
module sync_fifo_ext #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [DATA_WIDTH-1:0]        din,
   input  logic                         rd_en,
   input  logic                         clr_err,
   output logic [DATA_WIDTH-1:0]        dout,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  rd_acc, wr_acc;

   // Every flag comes from the registered count, so none depends on wr_en/rd_en.
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AFULL_THRESH));
   assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   always_comb begin
      rd_acc   = rd_en && !empty;
      wr_acc   = wr_en && (!full || rd_acc);
      wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A new error in the same cycle as clr_err wins.
      ovf_d = (wr_en && !wr_acc) || (ovf_q && !clr_err);
      udf_d = (rd_en && !rd_acc) || (udf_q && !clr_err);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dout = mem_q[rd_ptr_q];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               dout_q <= '0;
            end else if (rd_acc) begin
               dout_q <= mem_q[rd_ptr_q];
            end
         end
         assign dout = dout_q;
      end
   endgenerate

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised single-clock FIFO replacing the fixed 8-bit/16-deep buffer in the datapath. Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a compile-time choice between standard (registered-read) and first-word-fall-through (FWFT) output modes. Sits between any producer/consumer pair sharing `clk`.

## Interface
- `DATA_WIDTH`, 8, word width in bits (≥1).
- `DEPTH`, 16, number of entries; power of two, ≥2.
- `AFULL_THRESH`, DEPTH-2, `almost_full` asserts when count ≥ this value (1..DEPTH).
- `AEMPTY_THRESH`, 2, `almost_empty` asserts when count ≤ this value (0..DEPTH-1).
- `FWFT`, 0, 0 = standard mode, 1 = first-word-fall-through.
- `clk  in  1  clock; all state changes on rising edge.`
- `rst  in  1  reset, asynchronous, active-low (rst = 0 resets).`
- `wr_en  in  1  write request.`
- `din  in  DATA_WIDTH  write data, sampled when a write is accepted.`
- `rd_en  in  1  read request.`
- `clr_err  in  1  synchronous clear of overflow/underflow.`
- `dout  out  DATA_WIDTH  read data.`
- `full  out  1  count == DEPTH.`
- `empty  out  1  count == 0.`
- `almost_full  out  1  count ≥ AFULL_THRESH.`
- `almost_empty  out  1  count ≤ AEMPTY_THRESH.`
- `count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.`
- `overflow  out  1  sticky: a write was rejected.`
- `underflow  out  1  sticky: a read was rejected.`

## Operation
- Storage: DEPTH×DATA_WIDTH array; `wr_ptr`, `rd_ptr` of $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0; no reset of array contents.
- Read accepted (`rd_acc`) = `rd_en && !empty`. Write accepted (`wr_acc`) = `wr_en && (!full || rd_acc)`.
- Full + wr_en + rd_en: both accepted, count unchanged, pointers both advance.
- Empty + wr_en + rd_en: write accepted, read rejected (underflow set), count → 1.
- Count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both/neither.
- Rejected write (`wr_en && !wr_acc`) sets `overflow`; rejected read (`rd_en && !rd_acc`) sets `underflow`. Both hold until `clr_err` = 1 or reset. If clr_err and a new error occur in the same cycle, the flag stays set.
- Standard mode (FWFT=0): `dout` is a register loaded with `mem[rd_ptr]` on rd_acc; holds value otherwise.
- FWFT mode (FWFT=1): `dout` = `mem[rd_ptr]` combinationally; valid whenever `!empty`; rd_acc pops it. Content undefined while empty.
- All flags derived from the registered count, not from pointer comparison.

## Timing
- Reset (rst = 0, asynchronous): pointers 0, count 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0 (1 only if AFULL_THRESH = 0, not legal), overflow = 0, underflow = 0, standard-mode dout = 0. Reset mid-operation discards all contents immediately; first accepted write after release lands in slot 0.
- Release: first edge with rst = 1 may accept a write.
- Write-to-flag latency: flags and count reflect an operation from the rising edge on which it is accepted (visible in the following cycle).
- Standard read latency: data appears on `dout` one cycle after the edge sampling `rd_en`=1.
- FWFT latency: a word written into an empty FIFO appears on `dout` the cycle after the write edge (when `empty` deasserts).
- No combinational path from `wr_en`/`rd_en` to any output.

## Test plan
- Fill/drain, FWFT=0: write 10..25 on 16 consecutive cycles → full = 1, count = 16, almost_full from count 14; read 16 cycles → dout = 10..25 each one cycle after rd_en, empty = 1 at end.
- Overflow: write 17 words into DEPTH=16 → 17th rejected, overflow = 1, count stays 16, contents unchanged; clr_err pulse → overflow = 0.
- Underflow/empty simultaneity: empty FIFO, wr_en=rd_en=1 with din=0x5A → count = 1, underflow = 1; next read returns 0x5A.
- Full simultaneity and wrap: fill with 0..15, then 20 cycles of wr_en=rd_en=1 with din=100.. → count stays 16, reads return 0..15 then 100..103, no overflow.
- FWFT=1: write 0x33 to empty FIFO → dout = 0x33 next cycle with rd_en=0; write 0x44, rd_en pulse → dout = 0x44.
- Reset mid-operation: after 5 writes, assert rst low between edges → count = 0, empty = 1, flags cleared immediately; write 0x77 after release, read → 0x77.
